// File: rtl/cpu_cu_pkg.sv
// Shared definitions for the cpu_cu control unit: FSM state encoding,
// instruction class and control sub-opcode codes, control-word bit positions.
package cpu_cu_pkg;

    localparam int unsigned PC_W   = 9;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned OPS_W  = 9;
    localparam int unsigned CW_W   = 13;
    localparam int unsigned PSW_W  = 4;
    localparam int unsigned FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_FETCH0 = 2'd0,
        ST_FETCH1 = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    // Instruction class, op[6:5]
    localparam logic [1:0] CLS_ALU_REG = 2'b00;
    localparam logic [1:0] CLS_ALU_IMM = 2'b01;
    localparam logic [1:0] CLS_MEM     = 2'b10;
    localparam logic [1:0] CLS_CTRL    = 2'b11;

    // Control-class sub-opcodes, op[4:0]; unlisted codes are NOP
    localparam logic [4:0] SUB_JMP  = 5'h00;
    localparam logic [4:0] SUB_BZ   = 5'h01;
    localparam logic [4:0] SUB_BNZ  = 5'h02;
    localparam logic [4:0] SUB_BN   = 5'h03;
    localparam logic [4:0] SUB_BC   = 5'h04;
    localparam logic [4:0] SUB_HALT = 5'h1f;

    // Control-word bit positions
    localparam int unsigned CW_MW    = 0;
    localparam int unsigned CW_MM    = 1;
    localparam int unsigned CW_RW    = 2;
    localparam int unsigned CW_MD    = 3;
    localparam int unsigned CW_FS_LO = 4;
    localparam int unsigned CW_FS_HI = 8;
    localparam int unsigned CW_MB    = 9;
    localparam int unsigned CW_RA_LO = 10;
    localparam int unsigned CW_RA_HI = 12;

    // psw flag positions
    localparam int unsigned PSW_Z = 0;
    localparam int unsigned PSW_N = 1;
    localparam int unsigned PSW_C = 2;
    localparam int unsigned PSW_V = 3;

    // Fetch cycles only route pc to memory
    localparam logic [CW_W-1:0] CW_FETCH = CW_W'(1) << CW_MM;

endpackage

// File: rtl/cpu_dec.sv
// cpu_dec: combinational decode of the 7-bit opcode into the EXEC control word
// plus branch-taken and halt indications.
//   op     in  opcode of the current instruction
//   flags  in  {C, N, Z} from the datapath, sampled during EXEC
//   cw_c   out EXEC-cycle control word
//   take_c out jump/branch taken
//   halt_c out instruction is HALT
module cpu_dec
    import cpu_cu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FLAG_W-1:0] flags,
    output logic [CW_W-1:0]   cw_c,
    output logic              take_c,
    output logic              halt_c
);

    logic [1:0] cls;
    logic [4:0] sub;

    assign cls = op[6:5];
    assign sub = op[4:0];

    // Class decode; register-address bits and mm stay 0 in EXEC
    always_comb begin
        cw_c   = '0;
        take_c = 1'b0;
        halt_c = 1'b0;
        case (cls)
            CLS_ALU_REG: begin
                cw_c[CW_FS_HI:CW_FS_LO] = sub;
                cw_c[CW_RW]             = 1'b1;
            end
            CLS_ALU_IMM: begin
                cw_c[CW_FS_HI:CW_FS_LO] = sub;
                cw_c[CW_RW]             = 1'b1;
                cw_c[CW_MB]             = 1'b1;
            end
            CLS_MEM: begin
                if (sub[0]) begin
                    cw_c[CW_MW] = 1'b1;
                end else begin
                    cw_c[CW_MD] = 1'b1;
                    cw_c[CW_RW] = 1'b1;
                end
            end
            CLS_CTRL: begin
                case (sub)
                    SUB_JMP:  take_c = 1'b1;
                    SUB_BZ:   take_c = flags[PSW_Z];
                    SUB_BNZ:  take_c = ~flags[PSW_Z];
                    SUB_BN:   take_c = flags[PSW_N];
                    SUB_BC:   take_c = flags[PSW_C];
                    SUB_HALT: halt_c = 1'b1;
                    default:  ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_cu.sv
// cpu_cu: three-cycle fetch/fetch/execute control unit with HALT.
//   clk, rst  clock and synchronous active-high reset
//   din       memory read data at pc_out (combinational read)
//   psw       datapath flags {V, C, N, Z}
//   cw        registered control word for the current cycle
//   ir_ops    operand field of the most recently fetched instruction
//   pc_out    program counter
//   halted    high while in HALT
module cpu_cu
    import cpu_cu_pkg::*;
#(
    parameter int unsigned bw = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [bw-1:0]      din,
    input  logic [PSW_W-1:0]   psw,
    output logic [CW_W-1:0]    cw,
    output logic [OPS_W-1:0]   ir_ops,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [OPS_W-1:0]   ops_q, ops_d;
    logic [CW_W-1:0]    cw_q, cw_d;
    logic               halted_q, halted_d;

    logic [CW_W-1:0]    dec_cw_c;
    logic               dec_take_c;
    logic               dec_halt_c;

    // Overflow flag is not used by any branch
    logic               unused_psw_v;
    assign unused_psw_v = psw[PSW_V];

    cpu_dec u_dec (
        .op     (op_q),
        .flags  (psw[FLAG_W-1:0]),
        .cw_c   (dec_cw_c),
        .take_c (dec_take_c),
        .halt_c (dec_halt_c)
    );

    // Next state; cw/halted are computed for the state being entered
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        ops_d    = ops_q;
        cw_d     = '0;
        halted_d = 1'b0;
        case (state_q)
            ST_FETCH0: begin
                op_d     = din[7:1];
                ops_d[8] = din[0];
                pc_d     = pc_q + PC_W'(1);
                cw_d     = CW_FETCH;
                state_d  = ST_FETCH1;
            end
            ST_FETCH1: begin
                // op_q is already valid here, so EXEC's cw can be registered
                ops_d[7:0] = din[7:0];
                pc_d       = pc_q + PC_W'(1);
                cw_d       = dec_cw_c;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_take_c) begin
                    pc_d = ops_q;
                end
                if (dec_halt_c) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    cw_d    = CW_FETCH;
                    state_d = ST_FETCH0;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                cw_d    = CW_FETCH;
                state_d = ST_FETCH0;
            end
        endcase
    end

    // State and output registers; reset wins over every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH0;
            pc_q     <= '0;
            op_q     <= '0;
            ops_q    <= '0;
            cw_q     <= CW_FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_q     <= op_d;
            ops_q    <= ops_d;
            cw_q     <= cw_d;
            halted_q <= halted_d;
        end
    end

    assign cw     = cw_q;
    assign ir_ops = ops_q;
    assign pc_out = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_cpu_cu.sv
// tb_cpu_cu: scoreboard bench for cpu_cu. Stimulus writes each instruction
// into a behavioural memory just before it is fetched, computes the expected
// EXEC response from the instruction-set rules and queues it; a negedge
// monitor pops and compares whenever the DUT is in an execute cycle.
module tb_cpu_cu;

    typedef struct {
        logic [8:0]  pc;
        logic [12:0] cw;
        logic [8:0]  ops;
        logic [8:0]  nxt;
        bit          halt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic [3:0]  psw;
    logic [12:0] cw;
    logic [8:0]  ir_ops;
    logic [8:0]  pc_out;
    logic        halted;

    logic [7:0]  mem [0:511];
    exp_t        sb [$];
    int          n_checks;
    int          n_fail;
    bit          mon_en;
    logic [8:0]  mpc;

    cpu_cu #(.bw(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .psw    (psw),
        .cw     (cw),
        .ir_ops (ir_ops),
        .pc_out (pc_out),
        .halted (halted)
    );

    assign din = mem[pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference: expected EXEC control word
    function automatic logic [12:0] ref_cw(input logic [6:0] op);
        int cls = int'(op) / 32;
        int sub = int'(op) % 32;
        case (cls)
            0:       return 13'(sub * 16 + 4);
            1:       return 13'(512 + sub * 16 + 4);
            2:       return (sub % 2 == 1) ? 13'h001 : 13'h00C;
            default: return 13'h000;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [6:0] op, input logic [3:0] f);
        int sub = int'(op) % 32;
        if (int'(op) / 32 != 3) return 1'b0;
        case (sub)
            0:       return 1'b1;
            1:       return f[0];
            2:       return !f[0];
            3:       return f[1];
            4:       return f[2];
            default: return 1'b0;
        endcase
    endfunction

    // Place an instruction at the model pc, queue its expected result,
    // then let the DUT spend its three cycles on it.
    task automatic issue(input logic [6:0] op, input logic [8:0] ops, input logic [3:0] f);
        exp_t e;
        logic [8:0] a1;
        a1 = mpc + 9'd1;
        mem[mpc] = {op, ops[8]};
        mem[a1]  = ops[7:0];
        psw      = f;
        e.pc   = mpc;
        e.cw   = ref_cw(op);
        e.ops  = ops;
        e.halt = (op == 7'h7F);
        e.nxt  = ref_taken(op, f) ? ops : 9'((int'(mpc) + 2) % 512);
        sb.push_back(e);
        mpc = e.nxt;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic issue_rand();
        logic [6:0] op;
        int cls;
        cls = $urandom_range(0, 3);
        op  = 7'($urandom_range(0, 127));
        if (cls == 3) begin
            int s = $urandom_range(0, 6);
            op = (s < 5) ? 7'(96 + s) : 7'($urandom_range(101, 126));
        end
        if (op == 7'h7F) op = 7'h7E;
        issue(op, 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
    endtask

    // Hold reset two cycles, check reset state; leaves rst high at a negedge
    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_pc", 32'(pc_out), 32'h0);
        check("reset_cw", 32'(cw), 32'h002);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_ir_ops", 32'(ir_ops), 32'h0);
        mpc = 9'd0;
    endtask

    // Monitor: fetch cycles have mm=1; EXEC has mm=0 and halted=0
    initial begin
        logic [8:0] pend_pc, halt_pc;
        bit pend_v, pend_halt, in_halt;
        exp_t e;
        pend_v = 0; in_halt = 0; pend_pc = '0; halt_pc = '0; pend_halt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pend_v = 0;
                in_halt = 0;
            end else begin
                if (pend_v) begin
                    check("next_pc", 32'(pc_out), 32'(pend_pc));
                    check("next_halted", 32'(halted), 32'(pend_halt));
                    pend_v = 0;
                    if (pend_halt) begin
                        in_halt = 1;
                        halt_pc = pend_pc;
                    end
                end
                if (in_halt) begin
                    check("halt_pc_frozen", 32'(pc_out), 32'(halt_pc));
                    check("halt_cw", 32'(cw), 32'h0);
                    check("halt_flag", 32'(halted), 32'h1);
                end else if (cw[1] === 1'b1) begin
                    check("fetch_cw", 32'(cw), 32'h002);
                end else if (sb.size() == 0) begin
                    check("unexpected_exec", 32'(cw), 32'h002);
                end else begin
                    e = sb.pop_front();
                    check("exec_cw", 32'(cw), 32'(e.cw));
                    check("exec_ir_ops", 32'(ir_ops), 32'(e.ops));
                    check("exec_pc", 32'(pc_out), 32'((int'(e.pc) + 2) % 512));
                    check("exec_halted", 32'(halted), 32'h0);
                    pend_v = 1;
                    pend_pc = e.nxt;
                    pend_halt = e.halt;
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        mon_en = 0;
        psw = 4'h0;
        rst = 1'b1;
        mpc = 9'd0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;

        do_reset();
        rst = 1'b0;
        mon_en = 1'b1;
        // ALU register op: bytes 0x02, 0x53
        issue(7'h01, 9'h053, 4'h0);
        // BZ taken to 0x040, then BZ not taken
        issue(7'h61, 9'h040, 4'b0001);
        issue(7'h61, 9'h123, 4'b0000);
        // Store then load
        issue(7'h41, 9'h0A5, 4'h0);
        issue(7'h40, 9'h0A5, 4'h0);
        for (int i = 0; i < 80; i++) issue_rand();
        // Instruction at 510/511 wraps pc to 0, then HALT
        issue(7'h60, 9'h1FE, 4'h0);
        issue(7'h25, 9'h1C7, 4'h0);
        issue(7'h7F, 9'h000, 4'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        sb.delete();

        // Reset out of HALT, then reset during the EXEC cycle of a store
        do_reset();
        mem[0] = {7'h41, 1'b0};
        mem[1] = 8'h10;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("st_exec_mw", 32'(cw[0]), 32'h1);
        check("st_exec_rw", 32'(cw[2]), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_exec_cw", 32'(cw), 32'h002);
        check("rst_mid_exec_pc", 32'(pc_out), 32'h0);
        check("rst_mid_exec_halted", 32'(halted), 32'h0);
        rst = 1'b0;

        // A few more random instructions from a clean start
        do_reset();
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) issue_rand();
        repeat (2) @(negedge clk);
        check("scoreboard_drained_2", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
